tbus_rx: RTL
============

Name: tbus_rx

Overview:
- Receive-side controller for a half-duplex shared tristate bus built from bufz driver cells.
- Arbitrates bus direction between the local bufz driver array (through EN) and a remote driver.
- Inserts dead turnaround cycles so the two sides never drive the bus at the same time.
- Captures remote words into a small FIFO with a valid/ready read port.

Parameters:
- WIDTH, 8, bus and data width in bits.
- DEPTH, 4, receive FIFO depth in words; power of two, minimum 2.
- TA_CYCLES, 1, number of dead cycles inserted at every direction change; minimum 1.

Ports:
- CLK  input  1  single clock for the block; rising-edge.
- RN  input  1  asynchronous active-low reset.
- TX_REQ  input  1  local side requests to drive the bus.
- EN  output  1  enable for the local bufz driver array; 1 means the local side drives the bus.
- REQ_RX  input  1  remote side requests the bus; level, held for the whole transfer.
- GNT  output  1  bus granted to the remote side.
- BUS_I  input  WIDTH  bus value sampled from the pads.
- BUS_VLD  input  1  remote data strobe, one word per cycle.
- BUS_RDY  output  1  equals GNT & !FULL; combinational from registers only.
- Q  output  WIDTH  FIFO head word.
- Q_VLD  output  1  FIFO not empty.
- Q_RDY  input  1  consumer pops the head word when Q_VLD & Q_RDY.
- FULL  output  1  FIFO holds DEPTH words.
- OVF  output  1  sticky overflow flag.
- OVF_CLR  input  1  clears OVF.

Behaviour:
- Clock and reset: one clock, CLK. Reset RN is asynchronous and active-low.
- Reset values: state IDLE, EN=0, GNT=0, FIFO empty, Q_VLD=0, FULL=0, OVF=0, Q=0.
- EN must fall asynchronously when RN is asserted, including mid-transfer. This prevents bus contention.
- All outputs are registered except BUS_RDY.
- State machine (EN and GNT are Moore outputs of the state):
  - IDLE: EN=0, GNT=0.
    - REQ_RX=1 -> TA_IN. REQ_RX has priority over TX_REQ.
    - Otherwise TX_REQ=1 -> TX.
  - TX: EN=1.
    - REQ_RX=1 -> TA_IN.
    - Otherwise TX_REQ=0 -> IDLE.
  - TA_IN: EN=0, GNT=0. Stays exactly TA_CYCLES cycles, then -> RX.
    - If REQ_RX drops during TA_IN, the state still completes, then RX -> TA_OUT on the next cycle.
  - RX: GNT=1.
    - REQ_RX=0 -> TA_OUT.
  - TA_OUT: GNT=0, EN=0. Stays exactly TA_CYCLES cycles, then -> IDLE.
- Cycle timing: from REQ_RX rising in IDLE, GNT rises TA_CYCLES+1 edges later. EN and GNT are never 1 together, in any cycle.
- Turnaround counter: a single down-counter of width clog2(TA_CYCLES+1), shared by TA_IN and TA_OUT. It is loaded on entry to either state.
- FIFO push rule: a push is attempted when state==RX & BUS_VLD.
  - The push is accepted if !FULL, or if a pop occurs in the same cycle.
  - BUS_VLD outside RX is ignored and does not set OVF.
- Overflow: an attempted push with FULL=1 and no pop drops the word and sets OVF.
- OVF_CLR: clears OVF. If OVF_CLR and a new overflow occur in the same cycle, the set wins.
- Pop: happens when Q_VLD & Q_RDY. Q shows the new head on the next cycle.
- Simultaneous push and pop: the occupancy count is unchanged. On an empty FIFO only the push happens, since Q_VLD=0.
- FIFO implementation: read and write pointers of clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register of clog2(DEPTH)+1 bits. FULL = (count==DEPTH). Q_VLD = (count!=0).
- FIFO contents persist across direction changes. Only RN clears them.

Decomposition:
- Package tbus_pkg holds:
  - the state enum {IDLE, TX, TA_IN, RX, TA_OUT};
  - the TA counter width function;
  - the reset constants.
- Sub-module tbus_rx_fifo: synchronous FIFO with parameters WIDTH and DEPTH, the push/pop/full/empty interface, and the same CLK/RN.
- The top level contains the state machine, the turnaround counter and the OVF logic.

Test Plan:
- Reset during TX (TX_REQ=1, EN=1): assert RN=0 mid-cycle -> EN=0 immediately, before the next CLK edge; all outputs at their reset values.
- TA_CYCLES=2, IDLE, REQ_RX rises at edge 0 -> GNT=1 after edge 3, EN=0 throughout; REQ_RX falls -> GNT=0 next edge, then 2 dead cycles, then IDLE.
- TX_REQ=1 and REQ_RX=1 raised in the same cycle from IDLE -> EN stays 0, TA_IN entered, GNT is granted.
- DEPTH=4, RX with Q_RDY=0, 5 strobes carrying 0x11..0x55 -> FULL=1 after the 4th, OVF=1 after the 5th; popping gives 0x11, 0x22, 0x33, 0x44 in order.
- FULL with BUS_VLD=1 and Q_RDY=1 in the same cycle -> word accepted, OVF stays 0, count stays 4.
- OVF=1, OVF_CLR=1 together with a new overflow -> OVF stays 1; OVF_CLR alone -> OVF=0 on the next edge.

Source files
------------

// File: rtl/tbus_pkg.sv
// Shared types and constants for the tristate bus receive controller.
package tbus_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      TX     = 3'd1,
      TA_IN  = 3'd2,
      RX     = 3'd3,
      TA_OUT = 3'd4
   } state_e;

   function automatic int ta_cnt_w(input int ta);
      return (ta < 1) ? 1 : $clog2(ta + 1);
   endfunction

   localparam state_e RST_STATE = IDLE;
   localparam logic   RST_EN    = 1'b0;
   localparam logic   RST_GNT   = 1'b0;
   localparam logic   RST_OVF   = 1'b0;

endpackage

// File: rtl/tbus_rx_fifo.sv
// Receive FIFO with a registered head word so Q, Q_VLD and FULL
// all come straight from flops.
module tbus_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] head_o,
   output logic             vld_o,
   output logic             full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             vld_q, full_q;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      head_d = head_q;
      if (push_i) wptr_d = wptr_q + AW'(1);
      if (pop_i)  rptr_d = rptr_q + AW'(1);
      unique case ({push_i, pop_i})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
      // Head tracks the word that will sit at the read pointer next cycle.
      if (pop_i) begin
         if (cnt_q > (AW+1)'(1)) head_d = mem_q[rptr_q + AW'(1)];
         else if (push_i)        head_d = wdata_i;
      end else if (cnt_q == '0 && push_i) begin
         head_d = wdata_i;
      end
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         head_q <= '0;
         vld_q  <= 1'b0;
         full_q <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         head_q <= head_d;
         vld_q  <= (cnt_d != '0);
         full_q <= (cnt_d == FULL_CNT);
      end
   end

   always_ff @(posedge CLK) begin
      if (push_i) mem_q[wptr_q] <= wdata_i;
   end

   assign head_o = head_q;
   assign vld_o  = vld_q;
   assign full_o = full_q;

endmodule

// File: rtl/tbus_rx.sv
// Half-duplex bus direction arbiter with turnaround gaps and a
// receive FIFO for words driven by the remote side.
module tbus_rx
   import tbus_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int TA_CYCLES = 1
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             TX_REQ,
   output logic             EN,
   input  logic             REQ_RX,
   output logic             GNT,
   input  logic [WIDTH-1:0] BUS_I,
   input  logic             BUS_VLD,
   output logic             BUS_RDY,
   output logic [WIDTH-1:0] Q,
   output logic             Q_VLD,
   input  logic             Q_RDY,
   output logic             FULL,
   output logic             OVF,
   input  logic             OVF_CLR
);

   localparam int CW = ta_cnt_w(TA_CYCLES);
   localparam logic [CW-1:0] TA_LOAD = CW'(TA_CYCLES - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] ta_q, ta_d;
   logic          en_q, gnt_q;
   logic          ovf_q, ovf_d;
   logic          push_try, push_ok, pop, ovf_set;

   always_comb begin
      state_d = state_q;
      ta_d    = ta_q;
      unique case (state_q)
         IDLE: begin
            if (REQ_RX) begin
               state_d = TA_IN;
               ta_d    = TA_LOAD;
            end else if (TX_REQ) begin
               state_d = TX;
            end
         end
         TX: begin
            if (REQ_RX) begin
               state_d = TA_IN;
               ta_d    = TA_LOAD;
            end else if (!TX_REQ) begin
               state_d = IDLE;
            end
         end
         TA_IN: begin
            if (ta_q == '0) state_d = RX;
            else            ta_d    = ta_q - CW'(1);
         end
         RX: begin
            if (!REQ_RX) begin
               state_d = TA_OUT;
               ta_d    = TA_LOAD;
            end
         end
         TA_OUT: begin
            if (ta_q == '0) state_d = IDLE;
            else            ta_d    = ta_q - CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // gnt_q is high exactly while in RX, so it doubles as the RX decode.
   assign push_try = gnt_q & BUS_VLD;
   assign pop      = Q_VLD & Q_RDY;
   assign push_ok  = push_try & (~FULL | pop);
   assign ovf_set  = push_try & FULL & ~pop;

   always_comb begin
      ovf_d = ovf_q;
      if (OVF_CLR) ovf_d = 1'b0;
      if (ovf_set) ovf_d = 1'b1;
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q <= RST_STATE;
         ta_q    <= '0;
         en_q    <= RST_EN;
         gnt_q   <= RST_GNT;
         ovf_q   <= RST_OVF;
      end else begin
         state_q <= state_d;
         ta_q    <= ta_d;
         en_q    <= (state_d == TX);
         gnt_q   <= (state_d == RX);
         ovf_q   <= ovf_d;
      end
   end

   tbus_rx_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RN      (RN),
      .push_i  (push_ok),
      .pop_i   (pop),
      .wdata_i (BUS_I),
      .head_o  (Q),
      .vld_o   (Q_VLD),
      .full_o  (FULL)
   );

   assign EN      = en_q;
   assign GNT     = gnt_q;
   assign OVF     = ovf_q;
   assign BUS_RDY = gnt_q & ~FULL;

endmodule
